fetch_unit: RTL

Parametrised instruction-fetch engine for the lab CPU: owns PC, MAR, MDR and IR, and drives the SRAM control strobes for read-only instruction fetches. It presents each fetched instruction to the downstream decode stage with a valid/ready handshake. It supports free-running and single-step modes, PC redirect with squash of an in-flight fetch, and a configurable number of SRAM wait states.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch engine owning PC/MAR/MDR/IR, driving SRAM read strobes
// and presenting each fetched instruction to decode via a valid/ready handshake.
module fetch_unit #(
    parameter int                 DATA_W      = 16,
    parameter int                 ADDR_W      = 20,
    parameter int                 WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0]  PC_RESET    = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Stop,
    input  logic              Continue,
    input  logic              Step_mode,
    input  logic              PC_ld,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] PC,
    output logic              IR_valid,
    input  logic              IR_ready,
    output logic [15:0]       Instr_count,
    output logic              Halted
);
    typedef enum logic [2:0] {HALT, FETCH_ADDR, READ, LOAD_IR, ISSUE, PAUSE} state_t;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mdr;
    logic              stop_flag;
    logic              rd;

    // Strobes decode straight from the state register so an async reset releases the bus at once.
    assign rd       = state == READ;
    assign CE       = !rd;
    assign OE       = !rd;
    assign UB       = !rd;
    assign LB       = !rd;
    assign WE       = 1'b1;
    assign IR_valid = state == ISSUE;
    assign Halted   = state == HALT;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= HALT;
            cnt         <= '0;
            PC          <= PC_RESET;
            ADDR        <= '0;
            mdr         <= '0;
            IR          <= '0;
            Instr_count <= '0;
            stop_flag   <= 1'b0;
        end else begin
            if (state != HALT && Stop)
                stop_flag <= 1'b1;
            if (PC_ld)
                PC <= PC_in;
            case (state)
                HALT: begin
                    stop_flag <= 1'b0;
                    if (Run)
                        state <= FETCH_ADDR;
                end
                FETCH_ADDR: begin
                    if (!PC_ld) begin
                        ADDR  <= ADDR_W'(PC);
                        cnt   <= CW'(WAIT_CYCLES - 1);
                        state <= READ;
                    end
                end
                READ: begin
                    if (PC_ld)
                        state <= FETCH_ADDR;
                    else if (cnt == '0) begin
                        mdr   <= Mem_rdata;
                        state <= LOAD_IR;
                    end else
                        cnt <= cnt - 1'b1;
                end
                LOAD_IR: begin
                    if (PC_ld)
                        state <= FETCH_ADDR;
                    else begin
                        IR    <= mdr;
                        PC    <= PC + 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (IR_ready) begin
                        Instr_count <= Instr_count + 16'd1;
                        if (Stop || stop_flag) begin
                            state     <= HALT;
                            stop_flag <= 1'b0;
                        end else
                            state <= Step_mode ? PAUSE : FETCH_ADDR;
                    end
                end
                PAUSE: begin
                    if (Stop || stop_flag) begin
                        state     <= HALT;
                        stop_flag <= 1'b0;
                    end else if (Continue)
                        state <= FETCH_ADDR;
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule
